counter_handshake_sequencer: RTL and testbench
==============================================

Name: counter_handshake_sequencer

Overview:
Synchronous controller that sequences the 4-phase asynchronous counter chain.
- Input side: issues a commanded number of request handshakes on the chain input (ri/ai).
- Output side: acts as the environment at the chain output (ro/ao), acknowledging each output handshake after a programmable delay.
- Counts both sides, runs a per-phase watchdog, and reports completion or timeout to a synchronous host.

Parameters:
- CNT_W, 16, width of the command count and event counters.
- SYNC_STAGES, 2, flops in each synchroniser for ai and ro (minimum 2).
- ACK_DLY, 3, clk cycles from a synchronised ro edge to the matching ao edge (0 allowed).
- TIMEOUT, 1024, max clk cycles spent waiting in any single handshake phase.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host offers a command.
- cmd_ready  out  1  high only in IDLE.
- cmd_count  in  CNT_W  number of input handshakes to perform; 0 is legal.
- busy  out  1  high from command accept until done or err.
- done  out  1  one-cycle pulse when the command completes.
- err  out  1  sticky timeout flag; cleared only by reset.
- in_events  out  CNT_W  completed input handshakes for the current command.
- out_events  out  CNT_W  completed output handshakes since the last command accept.
- ri  out  1  request to chain input; registered output.
- ai  in  1  acknowledge from chain input; asynchronous.
- ro  in  1  request from chain output; asynchronous.
- ao  out  1  acknowledge to chain output; registered output.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high on `reset`.
  - Reset values: ri=0, ao=0, busy=0, done=0, err=0, in_events=0, out_events=0, cmd_ready=1. Synchroniser flops and all timers are cleared.
- Synchronisers:
  - ai and ro each pass through SYNC_STAGES flops. Only the synchronised versions ai_s and ro_s are used.
- Input FSM states: IDLE, RISE, FALL, DONE, ERR.
  - IDLE: cmd_ready=1. On cmd_valid:
    - latch cmd_count as target;
    - clear in_events and out_events;
    - busy=1;
    - go to DONE if target=0, otherwise to RISE with ri=1 registered on the same edge.
  - RISE: hold ri=1 until ai_s=1. Then ri=0 and go to FALL.
  - FALL: hold ri=0 until ai_s=0. Then in_events+1.
    - If in_events+1 = target, go to DONE.
    - Otherwise set ri=1 and go to RISE.
  - DONE: wait until the output side is quiescent (ro_s=0, ao=0, ack timer idle) for ACK_DLY+SYNC_STAGES+1 consecutive cycles. Then pulse done for 1 cycle, busy=0, go to IDLE.
  - ERR: ri=0, busy=0, cmd_ready=0. Stay until reset.
- Latency: minimum of one handshake (RISE entry to FALL exit) is 2·SYNC_STAGES+2 cycles.
- Watchdog:
  - Phase timer clears on every state change.
  - If it reaches TIMEOUT in RISE or FALL, go to ERR and set err=1.
  - The output side also sets err if ro_s holds one level for more than TIMEOUT cycles while ao already matches it.
- Output responder (independent of the input FSM, active outside ERR):
  - When ro_s != ao, start the ack timer. After ACK_DLY cycles, ao <= ro_s.
  - If ro_s reverts before expiry (glitch), cancel the timer without toggling ao.
  - When ao falls, out_events+1.
  - In ERR, ao holds its value.
- Width rules:
  - Counters saturate at 2^CNT_W−1; they never wrap.
  - in_events never exceeds target.
- Boundary conditions:
  - cmd_valid while busy: ignored, since cmd_ready=0.
  - ai_s and ro_s edges in the same cycle are handled independently.
  - reset mid-handshake: ri and ao drop to 0 the next edge. The environment must let the chain return to rest before a new command.
  - cmd_count=0: done pulses after the quiescence window; no ri activity.

Decomposition:
- Shared package `counter_seq_pkg`:
  - FSM state enum (IDLE/RISE/FALL/DONE/ERR);
  - default parameter constants;
  - a function for the quiescence window length.
- One natural sub-module, `hs_sync_responder`: synchroniser, ack-delay timer, ao register and out_events counter.
  - Also reusable as an environment for any 4-phase stage output.

Test Plan:
- Reset, then cmd_count=0 → no ri edge; done pulses once after ACK_DLY+SYNC_STAGES+1 idle cycles; in_events=0.
- Behavioural single toggle stage model (ai follows ri after 2 cycles), cmd_count=4:
  - exactly 4 ri pulses;
  - in_events=4;
  - done one cycle;
  - minimum handshake period 2·SYNC_STAGES+2 cycles plus model delay.
- Drive ro high for 10 cycles then low, ACK_DLY=3:
  - ao rises 3 cycles after ro_s rises;
  - ao falls 3 cycles after ro_s falls;
  - out_events=1.
- Stuck ai=0 with cmd_count=2 → err=1 exactly TIMEOUT cycles after RISE entry; ri=0; busy=0; cmd_ready stays 0 until reset.
- Assert reset during FALL with ri=0 → all outputs at reset values the next edge. A new command of 3 then completes with in_events=3.
- 1-cycle ro glitch (shorter than ACK_DLY) → ao unchanged; out_events unchanged.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - shared state type, defaults and quiescence window for the chain sequencer
package counter_seq_pkg;

  typedef enum logic [2:0] {S_IDLE, S_RISE, S_FALL, S_DONE, S_ERR} seq_state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_ACK_DLY     = 3;
  localparam int DEF_TIMEOUT     = 1024;

  // Cycles the output side must stay at rest before a command may report done.
  function automatic int quiet_window(input int ack_dly, input int sync_stages);
    return ack_dly + sync_stages + 1;
  endfunction

endpackage

// File: rtl/hs_sync_responder.sv
// rtl/hs_sync_responder.sv - synchronised 4-phase output-side responder with ack delay, event count and hold watchdog
module hs_sync_responder
  import counter_seq_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int ACK_DLY     = DEF_ACK_DLY,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             clear_events,
  input  logic             ro,
  output logic             ao,
  output logic [CNT_W-1:0] out_events,
  output logic             quiet,
  output logic             stuck
);

  localparam int AW = $clog2(ACK_DLY + 1) + 1;
  localparam int LW = $clog2(TIMEOUT + 1) + 1;

  logic [SYNC_STAGES-1:0] ro_sync;
  logic                   ro_s;
  logic [AW-1:0]          ack_timer;
  logic [LW-1:0]          hold_cnt;
  logic                   ack_fire;

  assign ro_s     = ro_sync[SYNC_STAGES-1];
  assign ack_fire = (ACK_DLY == 0) || (ack_timer == AW'(ACK_DLY - 1));
  assign quiet    = !ro_s && !ao && (ack_timer == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ro_sync    <= '0;
      ao         <= 1'b0;
      ack_timer  <= '0;
      hold_cnt   <= '0;
      out_events <= '0;
      stuck      <= 1'b0;
    end else begin
      ro_sync <= {ro_sync[SYNC_STAGES-2:0], ro};
      if (clear_events) out_events <= '0;
      if (!freeze) begin
        if (ro_s != ao) begin
          // A level must persist for the full delay; any reversion resets the timer.
          hold_cnt <= '0;
          if (ack_fire) begin
            ao        <= ro_s;
            ack_timer <= '0;
            if (ao && !clear_events && out_events != '1) out_events <= out_events + 1'b1;
          end else begin
            ack_timer <= ack_timer + 1'b1;
          end
        end else begin
          ack_timer <= '0;
          if (ro_s) begin
            if (hold_cnt == LW'(TIMEOUT)) stuck <= 1'b1;
            else hold_cnt <= hold_cnt + 1'b1;
          end else begin
            hold_cnt <= '0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/counter_handshake_sequencer.sv
// rtl/counter_handshake_sequencer.sv - host-commanded 4-phase input sequencer with output responder and watchdog
module counter_handshake_sequencer
  import counter_seq_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int ACK_DLY     = DEF_ACK_DLY,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] in_events,
  output logic [CNT_W-1:0] out_events,
  output logic             ri,
  input  logic             ai,
  input  logic             ro,
  output logic             ao
);

  localparam int QWIN = quiet_window(ACK_DLY, SYNC_STAGES);
  localparam int TMAX = (TIMEOUT > QWIN) ? TIMEOUT : QWIN;
  localparam int TW   = $clog2(TMAX + 1) + 1;

  seq_state_t             state;
  logic [CNT_W-1:0]       target;
  logic [CNT_W-1:0]       in_next;
  logic [TW-1:0]          timer;
  logic [SYNC_STAGES-1:0] ai_sync;
  logic                   ai_s;
  logic                   accept;
  logic                   quiet;
  logic                   stuck;
  logic                   timed_out;

  assign ai_s      = ai_sync[SYNC_STAGES-1];
  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_ready && cmd_valid;
  assign in_next   = (in_events == '1) ? in_events : in_events + 1'b1;
  assign timed_out = (timer == TW'(TIMEOUT - 1));

  hs_sync_responder #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .ACK_DLY(ACK_DLY), .TIMEOUT(TIMEOUT)
  ) u_resp (
    .clk(clk), .reset(reset), .freeze(state == S_ERR), .clear_events(accept),
    .ro(ro), .ao(ao), .out_events(out_events), .quiet(quiet), .stuck(stuck)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      target    <= '0;
      in_events <= '0;
      ri        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      timer     <= '0;
      ai_sync   <= '0;
    end else begin
      ai_sync <= {ai_sync[SYNC_STAGES-2:0], ai};
      done    <= 1'b0;
      timer   <= (timer == '1) ? timer : timer + 1'b1;
      if (stuck && state != S_ERR) begin
        state <= S_ERR;
        err   <= 1'b1;
        ri    <= 1'b0;
        busy  <= 1'b0;
        timer <= '0;
      end else begin
        case (state)
          S_IDLE: if (cmd_valid) begin
            target    <= cmd_count;
            in_events <= '0;
            busy      <= 1'b1;
            timer     <= '0;
            if (cmd_count == '0) state <= S_DONE;
            else begin
              state <= S_RISE;
              ri    <= 1'b1;
            end
          end
          S_RISE: if (ai_s) begin
            ri    <= 1'b0;
            state <= S_FALL;
            timer <= '0;
          end else if (timed_out) begin
            state <= S_ERR;
            err   <= 1'b1;
            ri    <= 1'b0;
            busy  <= 1'b0;
            timer <= '0;
          end
          S_FALL: if (!ai_s) begin
            in_events <= in_next;
            timer     <= '0;
            if (in_next == target) state <= S_DONE;
            else begin
              ri    <= 1'b1;
              state <= S_RISE;
            end
          end else if (timed_out) begin
            state <= S_ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
            timer <= '0;
          end
          // The phase timer doubles as the quiescence run-length counter here.
          S_DONE: if (!quiet) timer <= '0;
          else if (timer == TW'(QWIN - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
            timer <= '0;
          end
          S_ERR: begin
            ri   <= 1'b0;
            busy <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_handshake_sequencer.sv
// tb/tb_counter_handshake_sequencer.sv - self-checking bench for counter_handshake_sequencer
module tb_counter_handshake_sequencer;

  localparam int CNT_W = 16, SYNC = 2, ACK = 3, TO = 64, MD = 2, HN = 8192;

  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, ai = 1'b0, ro = 1'b0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic cmd_ready, busy, done, err, ri, ao;
  logic [CNT_W-1:0] in_events, out_events;

  int checks = 0, passed = 0, cyc = 0;
  bit ri_h[HN], ai_h[HN], ro_h[HN], rst_h[HN];
  bit ai_follow = 1, ai_force = 0, ro_next = 0, started = 0, ie_on = 0;
  int ri_rises = 0, ao_rises = 0, dones = 0;
  int ri_rise_c[$];
  int ao_rise_c = -1, ao_fall_c = -1, ro_rise_c = -1, ro_fall_c = -1, err_c = -1;
  int acc_cyc = -1, tgt = 0;

  counter_handshake_sequencer #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .ACK_DLY(ACK), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_count(cmd_count),
    .busy(busy), .done(done), .err(err), .in_events(in_events), .out_events(out_events),
    .ri(ri), .ai(ai), .ro(ro), .ao(ao)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic bit ros(input int j);
    return (j - SYNC >= 1) ? ro_h[j - SYNC] : 1'b0;
  endfunction

  // Environment: ai follows ri MD cycles later (toggle-stage model), ro from the sequence.
  initial begin
    bit pao, perr;
    pao = 0; perr = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= HN) begin
        $display("FAIL history_overflow: got %0d, expected below %0d", cyc, HN);
        $fatal(1);
      end
      ri_h[cyc]  = ri;
      rst_h[cyc] = reset;
      if (ri && !ri_h[cyc-1]) begin ri_rises++; ri_rise_c.push_back(cyc); end
      if (ao && !pao) begin ao_rises++; ao_rise_c = cyc; end
      if (!ao && pao) ao_fall_c = cyc;
      if (err && !perr) err_c = cyc;
      if (done) dones++;
      pao = ao; perr = err;
      ai = ai_follow ? ((cyc >= MD) ? ri_h[cyc-MD] : 1'b0) : ai_force;
      ai_h[cyc] = ai;
      if (ro_next && !ro) ro_rise_c = cyc;
      if (!ro_next && ro) ro_fall_c = cyc;
      ro = ro_next;
      ro_h[cyc] = ro;
    end
  end

  // Per-cycle compare against the behavioural model.
  initial begin
    bit ao_m, pdone, all_eq, v;
    int oe_m, n, c;
    ao_m = 0; oe_m = 0; pdone = 0;
    forever begin
      @(negedge clk);
      c = cyc;
      if (!started || c < ACK + SYNC + 2) continue;
      if (rst_h[c]) begin
        ao_m = 0; oe_m = 0;
      end else begin
        v = ros(c - 1);
        all_eq = 1;
        for (int k = 2; k <= ACK; k++) if (ros(c - k) != v) all_eq = 0;
        if (all_eq && v != ao_m) begin
          if (ao_m) oe_m++;
          ao_m = v;
        end
        if (c == acc_cyc) oe_m = 0;
      end
      chk("ao_model", ao, ao_m);
      chk("out_events_model", out_events, oe_m);
      if (ie_on && c >= acc_cyc) begin
        n = 0;
        for (int k = acc_cyc; k <= c - SYNC - 1; k++) if (ai_h[k-1] && !ai_h[k]) n++;
        if (n > tgt) n = tgt;
        chk("in_events_model", in_events, n);
      end
      chk("cmd_ready_rule", cmd_ready, !busy && !err);
      chk("done_one_cycle", done && pdone, 0);
      if (done) chk("done_clears_busy", busy, 0);
      if (err) chk("err_drops_ri", ri, 0);
      pdone = done;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic issue(input int n);
    cmd_count = CNT_W'(n);
    cmd_valid = 1'b1;
    acc_cyc   = cyc + 1;
    tgt       = n;
    ie_on     = 1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int dc);
    dc = -1;
    for (int i = 0; i < bound; i++) begin
      if (done) begin dc = cyc; return; end
      step();
    end
    chk("done_wait_bound", 0, 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ri"}, ri, 0);
    chk({tag, "_ao"}, ao, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_in_events"}, in_events, 0);
    chk({tag, "_out_events"}, out_events, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    int dc, r0, d0, a0;
    step();
    check_reset_values("reset");
    step(); step();
    reset = 1'b0;
    step();
    started = 1;

    // cmd_count = 0: done after a 6-cycle quiet window, no ri activity.
    r0 = ri_rises; d0 = dones;
    issue(0);
    wait_done(50, dc);
    chk("zero_done_latency", dc - acc_cyc, 6);
    chk("zero_no_ri", ri_rises - r0, 0);
    chk("zero_in_events", in_events, 0);
    repeat (10) step();
    chk("zero_done_pulses", dones - d0, 1);

    // Four handshakes through a 2-cycle toggle stage; a busy-time command is ignored.
    ri_rise_c.delete();
    r0 = ri_rises; d0 = dones;
    issue(4);
    repeat (15) step();
    chk("busy_mid_command", busy, 1);
    cmd_count = 16'd9; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    wait_done(500, dc);
    chk("four_ri_pulses", ri_rises - r0, 4);
    chk("four_in_events", in_events, 4);
    chk("four_period", (ri_rise_c.size() >= 2) ? ri_rise_c[1] - ri_rise_c[0] : -1, 10);
    repeat (10) step();
    chk("four_done_pulses", dones - d0, 1);

    // ro high for 10 cycles: ao follows ro_s after 3 cycles each way.
    repeat (5) step();
    ro_next = 1;
    repeat (11) step();
    ro_next = 0;
    repeat (15) step();
    chk("ao_rise_delay", ao_rise_c - ro_rise_c, 5);
    chk("ao_fall_delay", ao_fall_c - ro_fall_c, 5);
    chk("ro_out_events", out_events, 1);

    // One-cycle ro glitch is filtered.
    a0 = ao_rises;
    ro_next = 1;
    step();
    ro_next = 0;
    repeat (12) step();
    chk("glitch_no_ao", ao_rises - a0, 0);
    chk("glitch_ao_low", ao, 0);
    chk("glitch_out_events", out_events, 1);

    // Reset while in FALL, then a fresh command of 3.
    r0 = ri_rises;
    issue(3);
    for (int i = 0; i < 100; i++) begin
      if (ri_rises > r0 && !ri) break;
      step();
    end
    step();
    chk("fall_ri_low", ri, 0);
    reset = 1'b1; ie_on = 0;
    step();
    check_reset_values("midreset");
    reset = 1'b0;
    repeat (12) step();
    issue(3);
    wait_done(500, dc);
    chk("after_reset_in_events", in_events, 3);
    repeat (8) step();

    // Stuck ai: watchdog fires exactly TIMEOUT cycles after RISE entry.
    ai_follow = 0; ai_force = 0;
    ri_rise_c.delete();
    issue(2);
    for (int i = 0; i < 200; i++) begin
      if (err) break;
      step();
    end
    chk("stuck_err", err, 1);
    chk("stuck_err_latency", (ri_rise_c.size() >= 1) ? err_c - ri_rise_c[0] : -1, TO);
    chk("stuck_ri", ri, 0);
    chk("stuck_busy", busy, 0);
    chk("stuck_cmd_ready", cmd_ready, 0);
    repeat (5) step();
    cmd_count = 16'd1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("stuck_cmd_ready_held", cmd_ready, 0);
    chk("stuck_err_sticky", err, 1);
    reset = 1'b1; ie_on = 0;
    step();
    reset = 1'b0;
    step();
    chk("err_cleared_by_reset", err, 0);
    chk("ready_after_reset", cmd_ready, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
